// File: rtl/alu_seq.sv
// Registered N-bit ALU with valid/ready handshakes, status flags and an optional
// iterative shift-add multiplier (enabled by defining ALU_SEQ_MUL_EN).
module alu_seq #(
    parameter  int N   = 8,
    localparam int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         neg,
    output logic         ovf,
    output logic         busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
        MUL  = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t state;

    // Single-cycle ops; returns {ovf, carry, result}. Unhandled opcodes yield all-zero.
    function automatic logic [N+1:0] alu_op(input logic [2:0] opc,
                                            input logic [N-1:0] x,
                                            input logic [N-1:0] y);
        logic [N:0]     wide;
        logic [N:0]     shr_t;
        logic [N-1:0]   yb;
        logic [SHW-1:0] sh;
        logic           v;
        wide  = '0;
        shr_t = '0;
        yb    = ~y;
        sh    = y[SHW-1:0];
        v     = 1'b0;
        case (opc)
            OP_ADD: begin
                wide = {1'b0, x} + {1'b0, y};
                v    = (x[N-1] == y[N-1]) && (wide[N-1] != x[N-1]);
            end
            OP_SUB: begin
                wide = {1'b0, x} + {1'b0, yb} + {{N{1'b0}}, 1'b1};
                v    = (x[N-1] == yb[N-1]) && (wide[N-1] != x[N-1]);
            end
            OP_AND: wide = {1'b0, x & y};
            OP_OR:  wide = {1'b0, x | y};
            OP_XOR: wide = {1'b0, x ^ y};
            OP_SHL: wide = {1'b0, x} << sh;
            OP_SHR: begin
                // The guard bit below the LSB catches the last bit shifted out.
                shr_t = {x, 1'b0} >> sh;
                wide  = {shr_t[0], shr_t[N:1]};
            end
            default: wide = '0;
        endcase
        return {v, wide};
    endfunction

    logic [N+1:0] alu_nx;
    assign alu_nx = alu_op(op, a, b);

`ifdef ALU_SEQ_MUL_EN
    logic [2*N-1:0] prod;
    logic [2*N-1:0] mcand;
    logic [2*N-1:0] prod_nx;
    logic [N-1:0]   mplier;
    logic [SHW-1:0] cnt;

    assign prod_nx = prod + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            busy      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                        if (op == OP_MUL) begin
                            state  <= MUL;
                            busy   <= 1'b1;
                            prod   <= '0;
                            mcand  <= {{N{1'b0}}, a};
                            mplier <= b;
                            cnt    <= '0;
                        end else
`endif
                        begin
                            result    <= alu_nx[N-1:0];
                            carry     <= alu_nx[N];
                            ovf       <= alu_nx[N+1];
                            zero      <= (alu_nx[N-1:0] == '0);
                            neg       <= alu_nx[N-1];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                // One multiplier bit per cycle; the last step writes the product directly.
                MUL: begin
                    prod   <= prod_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (&cnt) begin
                        result    <= prod_nx[N-1:0];
                        carry     <= |prod_nx[2*N-1:N];
                        zero      <= (prod_nx[N-1:0] == '0);
                        neg       <= prod_nx[N-1];
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ALU_SEQ_MUL_EN
    assign busy = 1'b0;
`endif

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the team's combinational add/sub ALU.
- Adds logic ops, shifts, an optional iterative multiplier and status flags (C/Z/N/V).
- Uses a valid/ready handshake on both sides, so it can sit between the K2 decode stage and writeback with back-pressure.
- One operation in flight at a time.

Parameters:
- N, 8, operand/result width in bits; must be a power of two, N >= 4.
- SHW, $clog2(N), shift-amount width, derived; not to be overridden.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request
- a  in  N  operand A
- b  in  N  operand B; the low SHW bits are the shift amount for shifts
- op  in  3  operation select
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts the result
- result  out  N  registered result
- carry  out  1  carry / no-borrow / shifted-out bit / multiply high-half-nonzero
- zero  out  1  result == 0
- neg  out  1  result[N-1]
- ovf  out  1  signed overflow (ADD/SUB only, else 0)
- busy  out  1  high in MUL state

Behaviour:
- Reset (sync, rst=1 at clock edge): state=IDLE; in_ready=1; out_valid=0; result, carry, zero, neg, ovf all 0; busy=0. Reset overrides everything, including mid-MUL: the partial product is discarded and no result is emitted.
- States: IDLE, MUL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, a/b/op are captured.
  - Non-MUL op: result and flags are computed and registered, state goes to DONE. out_valid rises the next cycle (latency 1).
  - MUL op: state goes to MUL.
- MUL: shift-add, one multiplier bit per cycle, N cycles. Afterwards state goes to DONE. out_valid rises N+1 cycles after accept. in_ready=0. Input changes are ignored.
- DONE: out_valid=1 and outputs are held stable until out_ready=1. The handshake then completes and the block returns to IDLE the next cycle (out_valid=0, in_ready=1). There is no same-cycle accept while in DONE, so max throughput is 1 op per 2 cycles.
- Operations:
  - 000 ADD: {carry,result} = a+b over N+1 bits.
  - 001 SUB: {carry,result} = a+~b+1 over N+1 bits. carry=1 means no borrow; b=0 gives carry=1.
  - 010 AND, 011 OR, 100 XOR: carry=0.
  - 101 SHL: result = a << b[SHW-1:0]. carry = last bit shifted out of MSB; 0 when the amount is 0.
  - 110 SHR (logical): result = a >> amount. carry = last bit shifted out of LSB; 0 when the amount is 0.
  - 111 MUL: unsigned. result = low N bits of the 2N-bit product; carry = (high N bits != 0).
- Overflow: ovf = (a[N-1]==b'[N-1]) && (result[N-1]!=a[N-1]), where b' = b for ADD and ~b for SUB.
- All flags are registered together with result.
- Wrap-around: all arithmetic is modulo 2^N; no saturation.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: op 111 runs the iterative multiplier as described; MUL state and datapath are present.
- Not defined: the MUL state and multiplier logic are not synthesised. op 111 completes like a 1-cycle op with result=0, carry=0, ovf=0, neg=0, zero=1. busy is tied to 0.

Test Plan:
- N=8, ADD a=0xF0 b=0x20 -> next cycle out_valid=1, result=0x10, carry=1, ovf=0, zero=0.
- SUB a=0x80 b=0x01 -> result=0x7F, carry=1, ovf=1, neg=0. SUB a=0x05 b=0x00 -> result=0x05, carry=1.
- SHL a=0x81 b=0x01 -> result=0x02, carry=1. SHR a=0x03 b=0x02 -> result=0x00, carry=1, zero=1.
- MUL (macro defined) a=0x10 b=0x11 -> busy for 8 cycles, out_valid at accept+9, result=0x10, carry=1. Without macro -> result=0x00, zero=1 at accept+1.
- Back-pressure: hold out_ready=0 for 5 cycles after ADD 0x01+0x01 -> result=0x02 stable, in_ready=0 throughout. A new in_valid during the stall is not accepted. After the handshake, in_ready=1 the next cycle.
- Reset mid-MUL: assert rst at cycle 4 of MUL -> next cycle out_valid=0, busy=0, in_ready=1, result=0; no stale result ever presented.
